// File: rtl/ldm_stm_seq.sv
// LDM/STM block-transfer sequencer: walks a register list lowest-first, one req/ack
// memory beat per register, with an optional base writeback after the last beat.
module ldm_stm_seq (
  input  logic        clk,
  input  logic        Rst,
  input  logic        start,
  input  logic        L,
  input  logic [15:0] Reg_List,
  input  logic [31:0] Base,
  input  logic        U,
  input  logic        P,
  input  logic        W,
  input  logic [3:0]  Rn,
  output logic        busy,
  output logic        done,
  output logic        Mem_Req,
  input  logic        Mem_Ack,
  output logic        Mem_Write,
  output logic [31:0] Mem_Addr,
  output logic [31:0] Mem_WData,
  input  logic [31:0] Mem_RData,
  output logic [3:0]  R_Addr,
  input  logic [31:0] R_Data,
  output logic [3:0]  W_Addr,
  output logic [31:0] W_Data,
  output logic        Write_Reg,
  output logic        Write_PC,
  output logic [31:0] PC_New
);

  typedef enum logic [2:0] {IDLE, CALC, XFER, WB, DONE} state_t;

  state_t      state_q, state_d;
  logic        l_q, u_q, p_q, wb_q;
  logic [3:0]  rn_q;
  logic [15:0] list_q;   // registers still to transfer
  logic [31:0] base_q, addr_q, final_q;

  logic [4:0]  n;
  logic [31:0] n4, start_addr, final_base;
  logic [3:0]  cur_reg;
  logic [15:0] next_list;
  logic        last_beat;

  always_comb begin
    n = '0;
    for (int i = 0; i < 16; i++) n = n + {4'b0, list_q[i]};
    cur_reg = '0;
    for (int i = 15; i >= 0; i--) if (list_q[i]) cur_reg = 4'(i);
  end

  assign n4         = {25'b0, n, 2'b00};
  assign next_list  = list_q & ~(16'(1) << cur_reg);
  assign last_beat  = (next_list == '0);
  assign final_base = u_q ? base_q + n4 : base_q - n4;

  // Lowest register always lands at the lowest address, so decrement modes start low.
  always_comb begin
    case ({u_q, p_q})
      2'b10:   start_addr = base_q;
      2'b11:   start_addr = base_q + 32'd4;
      2'b00:   start_addr = base_q - n4 + 32'd4;
      default: start_addr = base_q - n4;
    endcase
  end

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = CALC;
      CALC: state_d = (n == '0) ? DONE : XFER;
      XFER: if (Mem_Ack && last_beat) state_d = wb_q ? WB : DONE;
      WB:   state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      l_q <= 1'b0; u_q <= 1'b0; p_q <= 1'b0; wb_q <= 1'b0;
      rn_q <= '0; list_q <= '0; base_q <= '0; addr_q <= '0; final_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          l_q    <= L;
          u_q    <= U;
          p_q    <= P;
          rn_q   <= Rn;
          list_q <= Reg_List;
          base_q <= {Base[31:2], 2'b00};
          // A loaded base wins over writeback.
          wb_q   <= W & ~(L & Reg_List[Rn]);
        end
        CALC: begin
          addr_q  <= start_addr;
          final_q <= final_base;
        end
        XFER: if (Mem_Ack) begin
          addr_q <= addr_q + 32'd4;
          list_q <= next_list;
        end
        default: ;
      endcase
    end
  end

  // Outputs decode from state only, so an asynchronous reset clears them at once.
  always_comb begin
    busy = (state_q != IDLE);
    done = 1'b0; Mem_Req = 1'b0; Mem_Write = 1'b0;
    Mem_Addr = '0; Mem_WData = '0; R_Addr = '0;
    W_Addr = '0; W_Data = '0; Write_Reg = 1'b0; Write_PC = 1'b0; PC_New = '0;
    case (state_q)
      XFER: begin
        Mem_Req   = 1'b1;
        Mem_Write = ~l_q;
        Mem_Addr  = addr_q;
        Mem_WData = R_Data;
        R_Addr    = cur_reg;
        if (Mem_Ack && l_q) begin
          if (cur_reg == 4'd15) begin
            Write_PC = 1'b1;
            PC_New   = Mem_RData;
          end else begin
            Write_Reg = 1'b1;
            W_Addr    = cur_reg;
            W_Data    = Mem_RData;
          end
        end
      end
      WB: begin
        Write_Reg = 1'b1;
        W_Addr    = rn_q;
        W_Data    = final_q;
      end
      DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ldm_stm_seq.sv
// Directed bench for ldm_stm_seq: every output is checked every cycle against a
// hand-written expected vector.
module tb_ldm_stm_seq;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, L, U, P, W, Mem_Ack;
  logic [15:0] Reg_List;
  logic [31:0] Base, Mem_RData, R_Data;
  logic [3:0]  Rn;
  logic        busy, done, Mem_Req, Mem_Write, Write_Reg, Write_PC;
  logic [31:0] Mem_Addr, Mem_WData, W_Data, PC_New;
  logic [3:0]  R_Addr, W_Addr;

  int total = 0;
  int bad   = 0;

  ldm_stm_seq dut (
    .clk(clk), .Rst(rst_n), .start(start), .L(L), .Reg_List(Reg_List), .Base(Base),
    .U(U), .P(P), .W(W), .Rn(Rn), .busy(busy), .done(done), .Mem_Req(Mem_Req),
    .Mem_Ack(Mem_Ack), .Mem_Write(Mem_Write), .Mem_Addr(Mem_Addr), .Mem_WData(Mem_WData),
    .Mem_RData(Mem_RData), .R_Addr(R_Addr), .R_Data(R_Data), .W_Addr(W_Addr),
    .W_Data(W_Data), .Write_Reg(Write_Reg), .Write_PC(Write_PC), .PC_New(PC_New)
  );

  always #5 clk = ~clk;

  logic [141:0] obs;
  assign obs = {busy, done, Mem_Req, Mem_Write, Write_Reg, Write_PC, R_Addr, W_Addr,
                Mem_Addr, Mem_WData, W_Data, PC_New};

  function automatic logic [141:0] pk(input logic b, d, rq, wr, wreg, wpc,
                                      input logic [3:0] ra, wa,
                                      input logic [31:0] ma, mwd, wd, pcn);
    return {b, d, rq, wr, wreg, wpc, ra, wa, ma, mwd, wd, pcn};
  endfunction

  task automatic launch(input logic l, input logic [15:0] lst, input logic [31:0] b,
                        input logic u, p, w, input logic [3:0] rn);
    @(negedge clk);
    start = 1'b1; L = l; Reg_List = lst; Base = b; U = u; P = p; W = w; Rn = rn;
    Mem_Ack = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    total++;
    if (obs !== '0) begin bad++; $display("FAIL reset got=%h exp=0", obs); end
  endtask

  task automatic test_ldmia;
    logic [141:0] exp;
    logic [31:0] md, rd;
    launch(1'b1, 16'h000F, 32'h1000, 1'b1, 1'b0, 1'b1, 4'd13);
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk);
      start = 1'b0; Mem_Ack = 1'b1;
      md = 32'hA000_0000 + 32'(cyc); rd = 32'h5555_0000 + 32'(cyc);
      Mem_RData = md; R_Data = rd;
      #1;
      if (cyc == 1)      exp = pk(1,0,0,0,0,0,4'd0,4'd0,32'h0,32'h0,32'h0,32'h0);
      else if (cyc <= 5) exp = pk(1,0,1,0,1,0,4'(cyc-2),4'(cyc-2),32'h1000 + 32'(4*(cyc-2)),rd,md,32'h0);
      else if (cyc == 6) exp = pk(1,0,0,0,1,0,4'd0,4'd13,32'h0,32'h0,32'h1010,32'h0);
      else if (cyc == 7) exp = pk(1,1,0,0,0,0,4'd0,4'd0,32'h0,32'h0,32'h0,32'h0);
      else               exp = '0;
      total++;
      if (obs !== exp) begin bad++; $display("FAIL ldmia cyc%0d got=%h exp=%h", cyc, obs, exp); end
    end
  endtask

  task automatic test_stmdb;
    logic [141:0] exp;
    logic [31:0] rd;
    launch(1'b0, 16'h4010, 32'h2000, 1'b0, 1'b1, 1'b1, 4'd13);
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clk);
      start = 1'b0; Mem_Ack = 1'b1;
      rd = 32'hC0DE_0000 + 32'(cyc);
      Mem_RData = 32'hFFFF_FFFF; R_Data = rd;
      #1;
      case (cyc)
        1: exp = pk(1,0,0,0,0,0,4'd0,4'd0,32'h0,32'h0,32'h0,32'h0);
        2: exp = pk(1,0,1,1,0,0,4'd4,4'd0,32'h1FF8,rd,32'h0,32'h0);
        3: exp = pk(1,0,1,1,0,0,4'd14,4'd0,32'h1FFC,rd,32'h0,32'h0);
        4: exp = pk(1,0,0,0,1,0,4'd0,4'd13,32'h0,32'h0,32'h1FF8,32'h0);
        5: exp = pk(1,1,0,0,0,0,4'd0,4'd0,32'h0,32'h0,32'h0,32'h0);
        default: exp = '0;
      endcase
      total++;
      if (obs !== exp) begin bad++; $display("FAIL stmdb cyc%0d got=%h exp=%h", cyc, obs, exp); end
    end
  endtask

  // Unaligned base: low address bits must be ignored.
  task automatic test_ldmib_pc;
    logic [141:0] exp;
    logic [31:0] rd;
    launch(1'b1, 16'h8001, 32'h3003, 1'b1, 1'b1, 1'b0, 4'd5);
    for (int cyc = 1; cyc <= 5; cyc++) begin
      @(negedge clk);
      start = 1'b0; Mem_Ack = 1'b1;
      rd = 32'h7777_0000 + 32'(cyc); R_Data = rd;
      Mem_RData = (cyc == 3) ? 32'hDEADBEE0 : 32'h0000_1234;
      #1;
      case (cyc)
        1: exp = pk(1,0,0,0,0,0,4'd0,4'd0,32'h0,32'h0,32'h0,32'h0);
        2: exp = pk(1,0,1,0,1,0,4'd0,4'd0,32'h3004,rd,32'h0000_1234,32'h0);
        3: exp = pk(1,0,1,0,0,1,4'd15,4'd0,32'h3008,rd,32'h0,32'hDEADBEE0);
        4: exp = pk(1,1,0,0,0,0,4'd0,4'd0,32'h0,32'h0,32'h0,32'h0);
        default: exp = '0;
      endcase
      total++;
      if (obs !== exp) begin bad++; $display("FAIL ldmib cyc%0d got=%h exp=%h", cyc, obs, exp); end
    end
  endtask

  task automatic test_wait_states;
    logic [141:0] exp;
    logic [31:0] md, rd;
    launch(1'b1, 16'h000F, 32'h1000, 1'b1, 1'b0, 1'b1, 4'd13);
    for (int cyc = 1; cyc <= 11; cyc++) begin
      @(negedge clk);
      start = 1'b0; Mem_Ack = !(cyc >= 3 && cyc <= 5);
      md = 32'hB000_0000 + 32'(cyc); rd = 32'h6666_0000 + 32'(cyc);
      Mem_RData = md; R_Data = rd;
      #1;
      case (cyc)
        1:       exp = pk(1,0,0,0,0,0,4'd0,4'd0,32'h0,32'h0,32'h0,32'h0);
        2:       exp = pk(1,0,1,0,1,0,4'd0,4'd0,32'h1000,rd,md,32'h0);
        3, 4, 5: exp = pk(1,0,1,0,0,0,4'd1,4'd0,32'h1004,rd,32'h0,32'h0);
        6:       exp = pk(1,0,1,0,1,0,4'd1,4'd1,32'h1004,rd,md,32'h0);
        7:       exp = pk(1,0,1,0,1,0,4'd2,4'd2,32'h1008,rd,md,32'h0);
        8:       exp = pk(1,0,1,0,1,0,4'd3,4'd3,32'h100C,rd,md,32'h0);
        9:       exp = pk(1,0,0,0,1,0,4'd0,4'd13,32'h0,32'h0,32'h1010,32'h0);
        10:      exp = pk(1,1,0,0,0,0,4'd0,4'd0,32'h0,32'h0,32'h0,32'h0);
        default: exp = '0;
      endcase
      total++;
      if (obs !== exp) begin bad++; $display("FAIL wait cyc%0d got=%h exp=%h", cyc, obs, exp); end
    end
  endtask

  // start held high mid-transfer must be ignored.
  task automatic test_ldmda_rn_in_list;
    logic [141:0] exp;
    logic [31:0] md, rd;
    launch(1'b1, 16'h0006, 32'h4000, 1'b0, 1'b0, 1'b1, 4'd2);
    for (int cyc = 1; cyc <= 5; cyc++) begin
      @(negedge clk);
      start = (cyc <= 4); Mem_Ack = 1'b1;
      md = 32'hD000_0000 + 32'(cyc); rd = 32'h8888_0000 + 32'(cyc);
      Mem_RData = md; R_Data = rd;
      #1;
      case (cyc)
        1: exp = pk(1,0,0,0,0,0,4'd0,4'd0,32'h0,32'h0,32'h0,32'h0);
        2: exp = pk(1,0,1,0,1,0,4'd1,4'd1,32'h3FFC,rd,md,32'h0);
        3: exp = pk(1,0,1,0,1,0,4'd2,4'd2,32'h4000,rd,md,32'h0);
        4: exp = pk(1,1,0,0,0,0,4'd0,4'd0,32'h0,32'h0,32'h0,32'h0);
        default: exp = '0;
      endcase
      total++;
      if (obs !== exp) begin bad++; $display("FAIL ldmda cyc%0d got=%h exp=%h", cyc, obs, exp); end
    end
    start = 1'b0;
  endtask

  task automatic test_empty_list;
    logic [141:0] exp;
    launch(1'b1, 16'h0000, 32'h5000, 1'b1, 1'b0, 1'b1, 4'd13);
    for (int cyc = 1; cyc <= 3; cyc++) begin
      @(negedge clk);
      start = 1'b0; Mem_Ack = 1'b1; Mem_RData = 32'h1; R_Data = 32'h2;
      #1;
      case (cyc)
        1: exp = pk(1,0,0,0,0,0,4'd0,4'd0,32'h0,32'h0,32'h0,32'h0);
        2: exp = pk(1,1,0,0,0,0,4'd0,4'd0,32'h0,32'h0,32'h0,32'h0);
        default: exp = '0;
      endcase
      total++;
      if (obs !== exp) begin bad++; $display("FAIL empty cyc%0d got=%h exp=%h", cyc, obs, exp); end
    end
  endtask

  task automatic test_reset_abort;
    logic [141:0] exp;
    logic [31:0] rd;
    launch(1'b1, 16'h000F, 32'h1000, 1'b1, 1'b0, 1'b1, 4'd13);
    for (int cyc = 1; cyc <= 3; cyc++) begin
      @(negedge clk);
      start = 1'b0; Mem_Ack = (cyc != 3); Mem_RData = 32'hE000_0000; rd = 32'h9999_0000; R_Data = rd;
      #1;
      case (cyc)
        1: exp = pk(1,0,0,0,0,0,4'd0,4'd0,32'h0,32'h0,32'h0,32'h0);
        2: exp = pk(1,0,1,0,1,0,4'd0,4'd0,32'h1000,rd,32'hE000_0000,32'h0);
        default: exp = pk(1,0,1,0,0,0,4'd1,4'd0,32'h1004,rd,32'h0,32'h0);
      endcase
      total++;
      if (obs !== exp) begin bad++; $display("FAIL abort cyc%0d got=%h exp=%h", cyc, obs, exp); end
    end
    rst_n = 1'b0; Mem_Ack = 1'b1;
    #1;
    total++;
    if (obs !== '0) begin bad++; $display("FAIL abort_immediate got=%h exp=0", obs); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      #1;
      total++;
      if (obs !== '0) begin bad++; $display("FAIL abort_after cyc%0d got=%h exp=0", cyc, obs); end
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; L = 1'b0; U = 1'b0; P = 1'b0; W = 1'b0; Mem_Ack = 1'b0;
    Reg_List = '0; Base = '0; Rn = '0; Mem_RData = '0; R_Data = '0;
    test_reset;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    test_ldmia;
    test_stmdb;
    test_ldmib_pc;
    test_wait_states;
    test_ldmda_rn_in_list;
    test_empty_list;
    test_reset_abort;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ldm_stm_seq.md
# ldm_stm_seq

Multi-register transfer sequencer for LDM/STM (IA/IB/DA/DB) block transfers. It walks a 16-bit register list and drives the register file's write side for loads, or its read port C for stores. Each register is moved through a single-beat req/ack memory handshake, and an optional base writeback to Rn follows. It sits between the decode/execute control and the banked register file plus data memory. Banked-register selection stays inside the register file via M; this block never sees M.

## Interface
Parameters: none (32-bit data/address, 16 architectural registers fixed).

Ports:
- clk  in  1  system clock, rising edge
- Rst  in  1  asynchronous, active-low reset
- start  in  1  begin transfer; sampled only in IDLE
- L  in  1  1 = LDM (memory → regs), 0 = STM (regs → memory)
- Reg_List  in  16  bit i set = transfer Ri
- Base  in  32  current Rn value
- U  in  1  1 = increment, 0 = decrement
- P  in  1  1 = before, 0 = after
- W  in  1  base writeback enable
- Rn  in  4  base register number
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle completion pulse
- Mem_Req  out  1  memory request
- Mem_Ack  in  1  memory acknowledge
- Mem_Write  out  1  1 = store beat
- Mem_Addr  out  32  beat address, word aligned
- Mem_WData  out  32  store data (= R_Data)
- Mem_RData  in  32  load data, valid in the ack cycle
- R_Addr  out  4  register read address (drives R_Addr_C)
- R_Data  in  32  combinational read data from the register file
- W_Addr  out  4  register write address
- W_Data  out  32  register write data
- Write_Reg  out  1  register write enable
- Write_PC  out  1  PC write enable
- PC_New  out  32  new PC value

## Operation
- States: IDLE → CALC → XFER → (WB) → DONE → IDLE.
- IDLE → CALC: when start = 1. All inputs are latched at this edge. start is ignored in any other state.
- CALC (1 cycle):
  - N = popcount(Reg_List).
  - Start address: IA = Base, IB = Base+4, DA = Base−4N+4, DB = Base−4N.
  - Final base: Base+4N if U = 1, else Base−4N.
  - Current register = lowest set bit. If N = 0, go straight to DONE: no memory beat, no writeback.
- XFER:
  - Mem_Req = 1, Mem_Write = ~L, Mem_Addr = current address, R_Addr = current register.
  - Mem_WData = R_Data, combinational.
  - Mem_Addr and R_Addr hold stable until Mem_Ack = 1.
- Ack cycle, LDM, current register ≠ 15: Write_Reg = 1, W_Addr = current register, W_Data = Mem_RData.
- Ack cycle, LDM, register 15: Write_PC = 1, PC_New = Mem_RData; Write_Reg stays 0.
- After each ack: address += 4, advance to the next higher set bit. Registers always go in ascending order to ascending addresses, whatever U is.
- Last ack: go to WB if W = 1 and not (L = 1 and Rn in list); otherwise go to DONE.
- WB (1 cycle): Write_Reg = 1, W_Addr = Rn, W_Data = final base.
- STM with Rn in list: the stored value is the original Rn, because writeback happens after all beats.
- DONE: done = 1 for one cycle, then IDLE.
- Arithmetic is modulo 2^32. Address wrap at 0xFFFFFFFC → 0 is silent.
- Address bits [1:0] of Base are forced to 0.
- S-bit (user-bank / CPSR restore) forms are out of scope.

## Timing
- Reset (asynchronous, Rst = 0): state = IDLE. Every output is 0: busy, done, Mem_Req, Mem_Write, Mem_Addr, Mem_WData, R_Addr, W_Addr, W_Data, Write_Reg, Write_PC, PC_New.
- Reset mid-transfer aborts immediately. Mem_Req drops in the same cycle Rst falls, and no partial writeback occurs.
- start at edge t0 → CALC in cycle t0+1 → first Mem_Req in cycle t0+2.
- Zero-wait memory: one beat per cycle, Mem_Req continuously high.
- Latency from start to done, with A = total ack-wait cycles: 1 (CALC) + N + A + (WB ? 1 : 0) + 1.
- Write_Reg, Write_PC and W_Data are combinational from Mem_Ack in XFER. The register file captures them at the ack-cycle edge.
- Mem_Ack outside XFER is ignored.

## Test plan
1. LDMIA, Base = 0x1000, Reg_List = 0x000F, W = 1, Rn = 13, Mem_Ack tied 1 → expected response:
   - Mem_Addr = 0x1000, 0x1004, 0x1008, 0x100C with W_Addr = 0..3.
   - WB cycle with W_Addr = 13, W_Data = 0x1010.
   - done 7 cycles after start.
2. STMDB, Base = 0x2000, Reg_List = 0x4010, W = 1, Rn = 13 → expected response:
   - Beat 1: Mem_Addr = 0x1FF8, R_Addr = 4. Beat 2: Mem_Addr = 0x1FFC, R_Addr = 14.
   - Mem_Write = 1 and Mem_WData = R_Data on both beats.
   - Writeback W_Data = 0x1FF8.
3. LDMIB, Base = 0x3000, Reg_List = 0x8001, Mem_RData = 0xDEADBEE0 on the second beat → expected response:
   - 0x3004 → R0.
   - 0x3008 → Write_PC = 1, PC_New = 0xDEADBEE0, Write_Reg = 0.
4. Hold Mem_Ack = 0 for 3 cycles on beat 2 → expected response:
   - Mem_Req, Mem_Addr and R_Addr stable throughout; no Write_Reg.
   - done delayed exactly 3 cycles.
5. LDMDA, Rn = 2, W = 1, Reg_List = 0x0006, Base = 0x4000 → expected response:
   - 0x3FFC → R1, 0x4000 → R2.
   - No WB cycle.
6. Two cases:
   - Reg_List = 0 → done 2 cycles after start, Mem_Req never asserted.
   - Separate run: Rst low during beat 2 of a 4-register LDM → all outputs 0 immediately, no further writes after release.
